alu_wb_stage: RTL and testbench
===============================

ALU_WB_STAGE -- requirements
Module: alu_wb_stage

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, width of the ALU result and writeback data.
REQ-002 The block SHALL have parameter REG_W, default 5, width of register-file indices.
REQ-003 The block SHALL have parameter RSTATUS_REG, default 30, register index that receives overflow status codes.
REQ-004 The block SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1, the upstream ALU result is valid this cycle.
REQ-007 The block SHALL have port in_ready, output, 1, the block accepts an entry this cycle.
REQ-008 The block SHALL have port in_result, input, DATA_W, ALU data_result.
REQ-009 The block SHALL have port in_overflow, input, 1, ALU overflow flag.
REQ-010 The block SHALL have port in_opcode, input, 5, ALU opcode that produced in_result.
REQ-011 The block SHALL have port in_is_addi, input, 1, the instruction is addi rather than an R-type add.
REQ-012 The block SHALL have port in_rd, input, REG_W, destination register.
REQ-013 The block SHALL have port in_wen, input, 1, the instruction writes a register.
REQ-014 The block SHALL have port wb_valid, output, 1, the head entry is presented.
REQ-015 The block SHALL have port wb_ready, input, 1, the register file consumes the head entry.
REQ-016 The block SHALL have ports wb_rd (output, REG_W), wb_data (output, DATA_W) and wb_wen (output, 1), the head entry's write target, data and enable.

Function
REQ-017 The block SHALL buffer entries in a 2-entry FIFO with an occupancy counter of 0..2 and 1-bit read/write pointers that wrap 1->0.
REQ-018 The block SHALL push when in_valid && in_ready, and pop when wb_valid && wb_ready.
REQ-019 in_ready SHALL equal (occupancy < 2) and SHALL NOT combinationally depend on wb_ready.
REQ-020 wb_valid SHALL equal (occupancy > 0); an accepted entry SHALL appear on the wb_* outputs exactly 1 cycle after acceptance when the FIFO was empty.
REQ-021 Simultaneous push and pop at occupancy 1 SHALL leave occupancy at 1 and preserve order.
REQ-022 At occupancy 2, in_ready SHALL be 0 and in_valid SHALL be ignored; pop alone SHALL decrement occupancy.
REQ-023 At occupancy 0, wb_rd, wb_data and wb_wen SHALL be 0.
REQ-024 Status mapping at push: if in_overflow=1 and in_opcode=00000, the stored entry SHALL be rd=RSTATUS_REG, wen=1, data=2 when in_is_addi=1 and data=1 otherwise.
REQ-025 Status mapping at push: if in_overflow=1 and in_opcode=00001, the stored entry SHALL be rd=RSTATUS_REG, wen=1, data=3.
REQ-026 in_overflow SHALL be ignored for all other opcodes (and, or, sll, sra).
REQ-027 After status mapping, an entry with rd=0 SHALL be stored with wen=0 but SHALL still be delivered and popped.
REQ-028 No entry SHALL be dropped, duplicated or reordered.

Reset
REQ-029 Assertion of reset at any time, including mid-transfer, SHALL immediately clear occupancy and pointers, forcing wb_valid=0, in_ready=1 and wb_* to 0; buffered entries SHALL be discarded.
REQ-030 The first push after reset deassertion SHALL be accepted normally.

Configuration
REQ-031 With ALU_WB_FWD_EN defined, the block SHALL add outputs fwd_valid (1), fwd_rd (REG_W) and fwd_data (DATA_W), equal to the youngest buffered entry with wen=1; fwd_valid SHALL be 0 when no such entry exists or after reset.
REQ-032 Without ALU_WB_FWD_EN, these ports and their logic SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-033 A shared package SHALL hold the opcode constants (ADD=00000, SUB=00001) and status codes (1, 2, 3), plus the entry record typedef {rd, data, wen}.
REQ-034 The FIFO storage SHALL be one sub-module, wb_fifo2; status mapping SHALL be in the top module.

Verification
REQ-035 The bench SHALL cover: push add rd=5, result 0x0000_0007, ovf=0 -> next cycle wb_valid=1, rd=5, data=7, wen=1.
REQ-036 The bench SHALL cover: push sub, ovf=1, rd=9 -> entry rd=30, data=3; push addi, ovf=1 -> data=2.
REQ-037 The bench SHALL cover: push and with ovf=1, rd=4, result 0xFF -> rd=4, data=0xFF (overflow ignored).
REQ-038 The bench SHALL cover: wb_ready=0 with three pushes -> in_ready=0 after the 2nd; the 3rd is held upstream; release delivers entries in order.
REQ-039 The bench SHALL cover: push rd=0 -> wb_valid=1, wb_wen=0; then assert reset with 2 entries buffered -> wb_valid=0, in_ready=1 within the same cycle.

Source files
------------

// File: rtl/alu_wb_stage_pkg.sv
// Shared definitions for the ALU writeback stage: opcodes, overflow status codes
// and the buffered entry record.
package alu_wb_stage_pkg;

   localparam logic [4:0] OP_ADD = 5'b00000;
   localparam logic [4:0] OP_SUB = 5'b00001;

   localparam int ST_ADD_OVF  = 1;
   localparam int ST_ADDI_OVF = 2;
   localparam int ST_SUB_OVF  = 3;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_REG_W  = 5;

   typedef struct packed {
      logic [DEF_REG_W-1:0]  rd;
      logic [DEF_DATA_W-1:0] data;
      logic                  wen;
   } wb_entry_t;

   function automatic logic is_status_op(input logic [4:0] op);
      return (op == OP_ADD) || (op == OP_SUB);
   endfunction

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry FIFO with an occupancy counter and 1-bit wrapping pointers.
// ALU_WB_FWD_EN exposes the youngest entry and occupancy for forwarding.
module wb_fifo2
   import alu_wb_stage_pkg::*;
#(
   parameter type entry_t = wb_entry_t
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       push_valid,
   output logic       push_ready,
   input  entry_t     push_data,
   output logic       pop_valid,
   input  logic       pop_ready,
   output entry_t     pop_data
`ifdef ALU_WB_FWD_EN
   ,output entry_t    tail_data
   ,output logic [1:0] count
`endif
);

   entry_t     mem [2];
   logic       wr_ptr, rd_ptr;
   logic [1:0] occ;
   logic       push, pop;

   assign push_ready = (occ < 2'd2);
   assign pop_valid  = (occ != 2'd0);
   assign push       = push_valid && push_ready;
   assign pop        = pop_valid && pop_ready;
   assign pop_data   = pop_valid ? mem[rd_ptr] : '0;

`ifdef ALU_WB_FWD_EN
   assign tail_data = mem[~wr_ptr];
   assign count     = occ;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         occ    <= 2'd0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
      end else begin
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         case ({push, pop})
            2'b10:   occ <= occ + 2'd1;
            2'b01:   occ <= occ - 2'd1;
            default: occ <= occ;
         endcase
      end
   end

   // Storage needs no reset: every read is qualified by occupancy.
   always_ff @(posedge clock) begin
      if (push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/alu_wb_stage.sv
// ALU writeback stage: maps add/sub overflow into status-register writes and
// buffers results in a 2-entry FIFO. ALU_WB_FWD_EN adds forwarding outputs.
module alu_wb_stage
   import alu_wb_stage_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int REG_W       = 5,
   parameter int RSTATUS_REG = 30
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_result,
   input  logic              in_overflow,
   input  logic [4:0]        in_opcode,
   input  logic              in_is_addi,
   input  logic [REG_W-1:0]  in_rd,
   input  logic              in_wen,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [REG_W-1:0]  wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_wen
`ifdef ALU_WB_FWD_EN
   ,output logic              fwd_valid
   ,output logic [REG_W-1:0]  fwd_rd
   ,output logic [DATA_W-1:0] fwd_data
`endif
);

   typedef struct packed {
      logic [REG_W-1:0]  rd;
      logic [DATA_W-1:0] data;
      logic              wen;
   } entry_t;

   entry_t in_entry, head;

   always_comb begin
      in_entry.rd   = in_rd;
      in_entry.data = in_result;
      in_entry.wen  = in_wen;
      if (in_overflow && is_status_op(in_opcode)) begin
         in_entry.rd  = REG_W'(RSTATUS_REG);
         in_entry.wen = 1'b1;
         if (in_opcode == OP_SUB)  in_entry.data = DATA_W'(ST_SUB_OVF);
         else if (in_is_addi)      in_entry.data = DATA_W'(ST_ADDI_OVF);
         else                      in_entry.data = DATA_W'(ST_ADD_OVF);
      end
      // r0 writes are still delivered so the pipeline stays in order.
      if (in_entry.rd == '0) in_entry.wen = 1'b0;
   end

`ifdef ALU_WB_FWD_EN
   entry_t     tail;
   logic [1:0] count;
`endif

   wb_fifo2 #(.entry_t(entry_t)) u_fifo (
      .clock      (clock),
      .reset      (reset),
      .push_valid (in_valid),
      .push_ready (in_ready),
      .push_data  (in_entry),
      .pop_valid  (wb_valid),
      .pop_ready  (wb_ready),
      .pop_data   (head)
`ifdef ALU_WB_FWD_EN
      ,.tail_data (tail)
      ,.count     (count)
`endif
   );

   assign wb_rd   = head.rd;
   assign wb_data = head.data;
   assign wb_wen  = head.wen;

`ifdef ALU_WB_FWD_EN
   // Youngest writer wins; with two entries the head is the older one.
   always_comb begin
      fwd_valid = 1'b0;
      fwd_rd    = '0;
      fwd_data  = '0;
      if (count != 2'd0 && tail.wen) begin
         fwd_valid = 1'b1;
         fwd_rd    = tail.rd;
         fwd_data  = tail.data;
      end else if (count == 2'd2 && head.wen) begin
         fwd_valid = 1'b1;
         fwd_rd    = head.rd;
         fwd_data  = head.data;
      end
   end
`endif

endmodule

// File: tb/tb_alu_wb_stage.sv
// Self-checking bench for alu_wb_stage: vector table plus backpressure and
// reset sequences, checked through an expected-entry scoreboard.
module tb_alu_wb_stage;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_result = '0;
   logic        in_overflow = 1'b0;
   logic [4:0]  in_opcode = '0;
   logic        in_is_addi = 1'b0;
   logic [4:0]  in_rd = '0;
   logic        in_wen = 1'b0;
   logic        wb_valid;
   logic        wb_ready = 1'b0;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        wb_wen;

   alu_wb_stage #(.DATA_W(32), .REG_W(5), .RSTATUS_REG(30)) dut (
      .clock(clock), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_result(in_result),
      .in_overflow(in_overflow), .in_opcode(in_opcode), .in_is_addi(in_is_addi),
      .in_rd(in_rd), .in_wen(in_wen),
      .wb_valid(wb_valid), .wb_ready(wb_ready),
      .wb_rd(wb_rd), .wb_data(wb_data), .wb_wen(wb_wen)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [4:0]  op;
      logic        ovf, addi, wen;
      logic [4:0]  rd;
      logic [31:0] res;
      logic [4:0]  erd;
      logic [31:0] edata;
      logic        ewen;
   } vec_t;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
      logic        wen;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   vec_t tbl[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic [4:0] op, input logic ovf, input logic addi,
                               input logic wen, input logic [4:0] rd, input logic [31:0] res,
                               input logic [4:0] erd, input logic [31:0] edata, input logic ewen);
      vec_t v;
      v.op = op; v.ovf = ovf; v.addi = addi; v.wen = wen; v.rd = rd; v.res = res;
      v.erd = erd; v.edata = edata; v.ewen = ewen;
      return v;
   endfunction

   // Drives one entry and holds it until accepted; the expected entry is queued
   // at the negedge preceding the accepting edge.
   task automatic send(input vec_t v);
      int n = 0;
      exp_t e;
      in_valid = 1'b1; in_opcode = v.op; in_overflow = v.ovf; in_is_addi = v.addi;
      in_wen = v.wen; in_rd = v.rd; in_result = v.res;
      @(negedge clock);
      while (!in_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      if (!in_ready) begin
         chk("accept_timeout", 64'd0, 64'd1);
      end else begin
         e.rd = v.erd; e.data = v.edata; e.wen = v.ewen;
         sb.push_back(e);
      end
      @(posedge clock); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 50) begin
         @(posedge clock); #1;
         n++;
      end
      chk("drain_empty", 64'(sb.size()), 64'd0);
   endtask

   always @(negedge clock) begin
      if (!wb_valid) begin
         chk("idle_zero", {wb_rd, wb_data, wb_wen}, 64'd0);
      end else if (!reset && wb_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_pop", 64'd1, 64'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("wb_rd", 64'(wb_rd), 64'(e.rd));
            chk("wb_data", 64'(wb_data), 64'(e.data));
            chk("wb_wen", 64'(wb_wen), 64'(e.wen));
         end
      end
   end

   initial begin
      tbl[0] = mk(5'b00000, 0, 0, 1, 5'd5,  32'h0000_0007, 5'd5,  32'h7,      1);
      tbl[1] = mk(5'b00001, 1, 0, 1, 5'd9,  32'h8000_0000, 5'd30, 32'd3,      1);
      tbl[2] = mk(5'b00000, 1, 1, 1, 5'd7,  32'h7FFF_FFFF, 5'd30, 32'd2,      1);
      tbl[3] = mk(5'b00000, 1, 0, 1, 5'd3,  32'h1111_0000, 5'd30, 32'd1,      1);
      tbl[4] = mk(5'b00010, 1, 0, 1, 5'd4,  32'h0000_00FF, 5'd4,  32'hFF,     1);
      tbl[5] = mk(5'b00011, 1, 0, 1, 5'd6,  32'h0000_1234, 5'd6,  32'h1234,   1);
      tbl[6] = mk(5'b00000, 0, 0, 1, 5'd0,  32'h0000_0055, 5'd0,  32'h55,     0);
      tbl[7] = mk(5'b00100, 0, 0, 0, 5'd8,  32'hA5A5_A5A5, 5'd8,  32'hA5A5_A5A5, 0);
      tbl[8] = mk(5'b00001, 0, 0, 1, 5'd12, 32'h0000_DEAD, 5'd12, 32'hDEAD,   1);
      tbl[9] = mk(5'b00000, 1, 0, 0, 5'd15, 32'h0000_0001, 5'd30, 32'd1,      1);

      repeat (3) @(posedge clock);
      #1;
      chk("rst_wb_valid", 64'(wb_valid), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_wb_out", {wb_rd, wb_data, wb_wen}, 64'd0);
      reset = 1'b0;
      wb_ready = 1'b1;
      @(posedge clock); #1;

      // One entry at a time from empty: visible exactly one cycle after acceptance.
      for (int i = 0; i < 10; i++) begin
         send(tbl[i]);
         chk("latency_valid", 64'(wb_valid), 64'd1);
         repeat (2) @(posedge clock);
         #1;
      end
      drain();

      // Back-to-back with a ready sink: simultaneous push/pop at occupancy 1.
      for (int i = 0; i < 5; i++) send(tbl[(i * 3) % 10]);
      drain();

      // Backpressure: third push held upstream until the sink releases.
      wb_ready = 1'b0;
      send(tbl[0]);
      send(tbl[1]);
      chk("full_in_ready", 64'(in_ready), 64'd0);
      fork
         send(tbl[4]);
         begin
            repeat (3) @(posedge clock);
            #1;
            chk("held_queue", 64'(sb.size()), 64'd2);
            chk("held_in_ready", 64'(in_ready), 64'd0);
            wb_ready = 1'b1;
         end
      join
      drain();

      // rd=0 is delivered with wen=0; reset with two entries buffered.
      wb_ready = 1'b0;
      send(tbl[6]);
      chk("r0_valid", 64'(wb_valid), 64'd1);
      chk("r0_wen", 64'(wb_wen), 64'd0);
      send(tbl[8]);
      chk("two_full", 64'(in_ready), 64'd0);
      #2;
      reset = 1'b1;
      sb.delete();
      #1;
      chk("mid_rst_valid", 64'(wb_valid), 64'd0);
      chk("mid_rst_ready", 64'(in_ready), 64'd1);
      chk("mid_rst_out", {wb_rd, wb_data, wb_wen}, 64'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      wb_ready = 1'b1;
      send(tbl[3]);
      chk("post_rst_valid", 64'(wb_valid), 64'd1);
      drain();

      repeat (2) @(posedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
